// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared constants and pad FSM state encoding for pad_hit_detector
package pad_pkg;

  localparam int NUM_PADS = 3;
  localparam int SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] DEF_THRESH  = 8'd64;
  localparam logic [SAMPLE_W-1:0] DEF_HYST    = 8'd16;
  localparam int                  DEF_HOLDOFF = 500000;
  localparam int                  DEF_CNT_W   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    REARM = 2'd2
  } pad_state_t;

endpackage

// File: rtl/pad_channel.sv
// rtl/pad_channel.sv - one pad: threshold compare, hold-off dead time, hysteresis re-arm
//   clock    in   system clock
//   reset    in   asynchronous active-high reset
//   i_sample in   synchronised pad reading
//   o_strike out  one-cycle strike pulse
module pad_channel
  import pad_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] THRESH  = DEF_THRESH,
  parameter logic [SAMPLE_W-1:0] HYST    = DEF_HYST,
  parameter int                  HOLDOFF = DEF_HOLDOFF,
  parameter int                  CNT_W   = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_strike
);

  // A misconfigured THRESH < HYST clamps the re-arm level to 0 so the pad never re-arms.
  localparam logic [SAMPLE_W-1:0] REARM_LVL = (THRESH >= HYST) ? SAMPLE_W'(THRESH - HYST) : '0;
  localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  pad_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_strike     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_sample >= THRESH) begin
          o_strike     = 1'b1;
          w_cnt_next   = HOLD_LOAD;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        // Readings are ignored until the dead time has fully expired.
        if (r_cnt == '0) begin
          w_state_next = REARM;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      REARM: begin
        if (i_sample < REARM_LVL) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/pad_hit_detector.sv
// rtl/pad_hit_detector.sv - synchronise pad readings, detect hits, grade against lit pad
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   sensor_input in   packed pad readings, pad i in byte i, [31:24] unused
//   lit_pad      in   one-hot pad currently lit
//   hit_ack      in   consumer pulse, clears hit_valid
//   hit_valid    out  hit event pending
//   hit_pad      out  pad(s) struck in pending event
//   hit_correct  out  pending event matched lit_pad
//   mistake      out  one-cycle pulse per wrong event
//   overrun      out  sticky, strike dropped while an event was pending
//   hit_count    out  saturating count of correct events
module pad_hit_detector
  import pad_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] THRESH  = DEF_THRESH,
  parameter logic [SAMPLE_W-1:0] HYST    = DEF_HYST,
  parameter int                  HOLDOFF = DEF_HOLDOFF,
  parameter int                  CNT_W   = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         sensor_input,
  input  logic [NUM_PADS-1:0] lit_pad,
  input  logic                hit_ack,
  output logic                hit_valid,
  output logic [NUM_PADS-1:0] hit_pad,
  output logic                hit_correct,
  output logic                mistake,
  output logic                overrun,
  output logic [15:0]         hit_count
);

  localparam int IN_W = NUM_PADS * SAMPLE_W;

  logic [IN_W-1:0]     r_s1, r_s2;
  logic [NUM_PADS-1:0] w_strike;
  logic                w_load_ok;
  logic                w_correct;
  logic                w_unused;

  logic                r_hit_valid;
  logic [NUM_PADS-1:0] r_hit_pad;
  logic                r_hit_correct;
  logic                r_mistake;
  logic                r_overrun;
  logic [15:0]         r_hit_count;

  assign w_unused = ^sensor_input[31:IN_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sensor_input[IN_W-1:0];
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_channel #(
      .THRESH (THRESH),
      .HYST   (HYST),
      .HOLDOFF(HOLDOFF),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .i_sample(r_s2[i*SAMPLE_W +: SAMPLE_W]),
      .o_strike(w_strike[i])
    );
  end

  // An ack in the same cycle frees the slot, so a new strike can replace the pending event.
  assign w_load_ok = !r_hit_valid || hit_ack;
  assign w_correct = (lit_pad != '0) && ((w_strike & ~lit_pad) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit_valid   <= 1'b0;
      r_hit_pad     <= '0;
      r_hit_correct <= 1'b0;
      r_mistake     <= 1'b0;
      r_overrun     <= 1'b0;
      r_hit_count   <= '0;
    end else begin
      r_mistake <= 1'b0;
      if (w_strike != '0) begin
        if (w_load_ok) begin
          r_hit_valid   <= 1'b1;
          r_hit_pad     <= w_strike;
          r_hit_correct <= w_correct;
          r_mistake     <= !w_correct;
          if (hit_ack) begin
            r_overrun <= 1'b0;
          end
          if (w_correct && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
          end
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (hit_ack && r_hit_valid) begin
        r_hit_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
    end
  end

  assign hit_valid   = r_hit_valid;
  assign hit_pad     = r_hit_pad;
  assign hit_correct = r_hit_correct;
  assign mistake     = r_mistake;
  assign overrun     = r_overrun;
  assign hit_count   = r_hit_count;

endmodule

// File: tb/tb_pad_hit_detector.sv
// tb/tb_pad_hit_detector.sv - self-checking bench for pad_hit_detector
module tb_pad_hit_detector;

  logic        clock;
  logic        reset;
  logic [31:0] sensor_input;
  logic [2:0]  lit_pad;
  logic        hit_ack;
  logic        hit_valid;
  logic [2:0]  hit_pad;
  logic        hit_correct;
  logic        mistake;
  logic        overrun;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  pad;
    logic        correct;
    logic [15:0] count;
  } exp_t;

  exp_t sb[$];

  pad_hit_detector #(
    .THRESH (8'd64),
    .HYST   (8'd16),
    .HOLDOFF(8),
    .CNT_W  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sensor_input(sensor_input),
    .lit_pad     (lit_pad),
    .hit_ack     (hit_ack),
    .hit_valid   (hit_valid),
    .hit_pad     (hit_pad),
    .hit_correct (hit_correct),
    .mistake     (mistake),
    .overrun     (overrun),
    .hit_count   (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] pad, input logic correct, input logic [15:0] count);
    exp_t e;
    e.pad     = pad;
    e.correct = correct;
    e.count   = count;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (hit_valid !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_arrive"}, {31'd0, hit_valid}, 32'd1);
  endtask

  task automatic check_event(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pad"},     {29'd0, hit_pad},     {29'd0, e.pad});
      chk({tag, "_correct"}, {31'd0, hit_correct}, {31'd0, e.correct});
      chk({tag, "_count"},   {16'd0, hit_count},   {16'd0, e.count});
    end
  endtask

  task automatic ack_pulse();
    hit_ack = 1'b1;
    step(1);
    hit_ack = 1'b0;
  endtask

  initial begin
    int extra;
    reset        = 1'b1;
    sensor_input = '0;
    lit_pad      = '0;
    hit_ack      = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_valid",   {31'd0, hit_valid},   32'd0);
    chk("rst_pad",     {29'd0, hit_pad},     32'd0);
    chk("rst_correct", {31'd0, hit_correct}, 32'd0);
    chk("rst_mistake", {31'd0, mistake},     32'd0);
    chk("rst_overrun", {31'd0, overrun},     32'd0);
    chk("rst_count",   {16'd0, hit_count},   32'd0);

    // First hit, with exact latency, then reset while pad0 is in its hold-off.
    lit_pad = 3'b001;
    sensor_input[7:0] = 8'd100;
    push_exp(3'b001, 1'b1, 16'd1);
    step(2);
    chk("lat_pre", {31'd0, hit_valid}, 32'd0);
    step(1);
    chk("lat_edge3", {31'd0, hit_valid}, 32'd1);
    check_event("hit1");
    step(2);
    reset = 1'b1;
    sensor_input[7:0] = 8'd0;
    step(1);
    reset = 1'b0;
    chk("midrst_valid", {31'd0, hit_valid}, 32'd0);
    chk("midrst_count", {16'd0, hit_count}, 32'd0);
    chk("midrst_pad",   {29'd0, hit_pad},   32'd0);
    step(1);
    sensor_input[7:0] = 8'd100;
    push_exp(3'b001, 1'b1, 16'd1);
    step(3);
    chk("after_rst_lat", {31'd0, hit_valid}, 32'd1);
    check_event("hit_after_rst");
    chk("hit_after_rst_mistake", {31'd0, mistake}, 32'd0);
    ack_pulse();
    chk("ack_clears", {31'd0, hit_valid}, 32'd0);
    sensor_input[7:0] = 8'd0;
    step(12);

    // Wrong pad struck.
    lit_pad = 3'b010;
    sensor_input[23:16] = 8'd200;
    push_exp(3'b100, 1'b0, 16'd1);
    wait_valid("wrong", 6);
    check_event("wrong");
    chk("wrong_mistake_hi", {31'd0, mistake}, 32'd1);
    step(1);
    chk("wrong_mistake_lo", {31'd0, mistake}, 32'd0);
    ack_pulse();
    sensor_input[23:16] = 8'd0;
    step(12);

    // Debounce and hysteresis on pad1.
    sensor_input[15:8] = 8'd100;
    push_exp(3'b010, 1'b1, 16'd2);
    wait_valid("deb", 6);
    check_event("deb");
    ack_pulse();
    extra = 0;
    repeat (50) begin
      step(1);
      if (hit_valid === 1'b1) extra++;
    end
    chk("deb_single", extra, 32'd0);
    sensor_input[15:8] = 8'd55;
    step(5);
    sensor_input[15:8] = 8'd100;
    step(10);
    chk("no_rearm_55", {31'd0, hit_valid}, 32'd0);
    sensor_input[15:8] = 8'd40;
    step(4);
    sensor_input[15:8] = 8'd100;
    push_exp(3'b010, 1'b1, 16'd3);
    wait_valid("rearm", 6);
    check_event("rearm");
    ack_pulse();
    sensor_input[15:8] = 8'd0;
    step(12);

    // Simultaneous strikes, overrun, and ack coinciding with a new strike.
    lit_pad = 3'b011;
    sensor_input[15:0] = 16'h6464;
    push_exp(3'b011, 1'b1, 16'd4);
    wait_valid("simul", 6);
    check_event("simul");
    sensor_input[23:16] = 8'd100;
    step(4);
    chk("ovr_set",   {31'd0, overrun},   32'd1);
    chk("ovr_pad",   {29'd0, hit_pad},   32'd3);
    chk("ovr_count", {16'd0, hit_count}, 32'd4);
    sensor_input[23:0] = '0;
    step(12);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    sensor_input[7:0] = 8'd100;
    step(2);
    hit_ack = 1'b1;
    step(1);
    hit_ack = 1'b0;
    push_exp(3'b001, 1'b1, 16'd5);
    chk("ackstrike_valid",   {31'd0, hit_valid}, 32'd1);
    chk("ackstrike_overrun", {31'd0, overrun},   32'd0);
    check_event("ackstrike");
    ack_pulse();
    sensor_input[7:0] = 8'd0;
    step(12);

    // Saturation of the correct-hit counter.
    force dut.r_hit_count = 16'hFFFE;
    #1;
    release dut.r_hit_count;
    lit_pad = 3'b001;
    sensor_input[7:0] = 8'd100;
    push_exp(3'b001, 1'b1, 16'hFFFF);
    wait_valid("sat1", 6);
    check_event("sat1");
    ack_pulse();
    sensor_input[7:0] = 8'd0;
    step(12);
    sensor_input[7:0] = 8'd100;
    push_exp(3'b001, 1'b1, 16'hFFFF);
    wait_valid("sat2", 6);
    check_event("sat2");
    ack_pulse();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_hit_detector.md
Name: pad_hit_detector

Overview:
- Front-end for the drum-pad sensors; sits directly upstream of the processor's sensor read (address 0) and alongside the VGA controller's sensor_input path.
- Synchronises the three 8-bit pad readings packed in sensor_input[23:0] and turns threshold crossings into debounced, one-per-strike hit events.
- Grades each hit against the currently lit pad and holds the result in a valid/ack register that the processor drains.

Parameters:
- NUM_PADS, 3, number of pads; byte i of sensor_input belongs to pad i.
- SAMPLE_W, 8, bits per pad reading.
- THRESH, 8'd64, strike threshold; a reading at or above it counts as a strike.
- HYST, 8'd16, re-arm hysteresis; a pad re-arms only when its reading is below THRESH-HYST.
- HOLDOFF, 500000, dead time in clocks after a strike (10 ms at 50 MHz); must be at least 1.
- CNT_W, 20, width of the hold-off counter; must satisfy 2^CNT_W > HOLDOFF.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- sensor_input  in  32  raw pad readings; [7:0] pad0, [15:8] pad1, [23:16] pad2; [31:24] ignored.
- lit_pad  in  3  one-hot pad currently lit, taken from sensor_output[2:0].
- hit_ack  in  1  consumer pulse; clears hit_valid.
- hit_valid  out  1  a hit event is pending.
- hit_pad  out  3  pad(s) struck in the pending event; multi-hot if several pads struck in the same cycle.
- hit_correct  out  1  pending event matched lit_pad.
- mistake  out  1  one-cycle pulse per wrong strike.
- overrun  out  1  sticky; a strike was dropped while hit_valid was held.
- hit_count  out  16  count of correct strikes, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - Synchroniser flops 0.
  - Every pad FSM goes to IDLE with its counter at 0.
- Input sync:
  - sensor_input[23:0] passes through two flop stages, s1 then s2. The FSMs see only s2.
  - lit_pad is used unsynchronised; it comes from the same clock domain.
- Per-pad FSM (independent instances):
  - IDLE: if s2 byte >= THRESH, raise strike_i for one cycle, load counter with HOLDOFF-1 and go to HOLD.
  - HOLD: decrement the counter. When the counter is 0, go to REARM. Readings are ignored in this state.
  - REARM: if s2 byte < THRESH-HYST, go to IDLE; otherwise stay.
  - All comparisons are unsigned. If THRESH < HYST, the re-arm level is 0, so the pad never re-arms (configuration error; not checked).
- Strike vector: strike = {strike_2, strike_1, strike_0}, combinational from the FSMs and consumed the same cycle.
- Event register, evaluated on every edge where strike != 0:
  - Load allowed when hit_valid=0, or when hit_ack=1 in that same cycle. Then hit_valid<=1, hit_pad<=strike, hit_correct<=(lit_pad!=0 && (strike & ~lit_pad)==0).
  - Load not allowed (hit_valid=1, hit_ack=0): strike dropped, overrun<=1. hit_pad and hit_correct are unchanged.
- Ack and overrun:
  - hit_ack with no strike: hit_valid<=0 and overrun<=0.
  - hit_ack while hit_valid=0 has no effect.
  - A strike that is loaded in an ack cycle clears overrun.
- Mistake and count:
  - mistake pulses high for one cycle on the load edge of an incorrect event.
  - Dropped strikes do not set mistake and do not change hit_count.
  - hit_count increments on the load edge of a correct event and saturates at 16'hFFFF.
- Latency: the raw value is captured into s1 on edge E. The event loads on edge E+2, so hit_valid is high in the cycle after edge E+2.
- Minimum spacing between two events from one pad is HOLDOFF+1 clocks plus the time spent in REARM.

Decomposition:
- Shared package pad_pkg:
  - Constants: NUM_PADS, SAMPLE_W, default THRESH/HYST/HOLDOFF.
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, REARM=2'd2.
- Sub-module pad_channel: one pad's comparator, FSM and hold-off counter, outputting strike_i. Instantiate NUM_PADS copies with a generate loop.
- The top holds the synchroniser, event register, grading logic and counter.

Test Plan (bench uses HOLDOFF=8, THRESH=64, HYST=16):
- Reset mid-HOLD: pad0=100, assert reset for 1 cycle -> all outputs 0 and all FSMs IDLE. A second strike is accepted once the reading drops below 48 and rises to 100 again.
- Single correct hit: lit_pad=001, pad0 0→100 -> hit_valid rises 3 edges after the input change, hit_pad=001, hit_correct=1, hit_count=1, mistake stays 0. hit_ack clears hit_valid.
- Wrong pad: lit_pad=010, pad2 0→200 -> hit_pad=100, hit_correct=0, one-cycle mistake, hit_count unchanged.
- Debounce and hysteresis:
  - Hold pad1 at 100 for 50 cycles -> exactly one event.
  - Drop to 55 -> no re-arm.
  - Drop to 40, then back to 100 -> second event.
- Simultaneous strikes and overrun:
  - Pads 0 and 1 both go to 100 in the same cycle -> hit_pad=011.
  - Pad2 strikes before any ack -> overrun=1, hit_pad still 011.
  - Ack in the same cycle as a new strike -> new event loaded, hit_valid stays 1, overrun=0.
- Saturation: preload hit_count to 16'hFFFE, apply two correct hits -> hit_count=FFFF, then stays FFFF.
